// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer parameter loader.
package layer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam int unsigned CHECKSUM_W = 16;

    // LSB of row r's bias field; row 0 sits in the most-significant field.
    function automatic int unsigned bias_lsb(input int unsigned r,
                                             input int unsigned n_rows,
                                             input int unsigned dw);
        return (n_rows - 1 - r) * 2 * dw;
    endfunction

endpackage

// File: rtl/layer_param_loader.sv
// Write-side sequencer streaming per-row weight/bias beats into a layer's update port.
// Optional running checksum of accepted beats: define LAYER_LOADER_CHECKSUM_EN.
module layer_param_loader
    import layer_pkg::*;
#(
    parameter int unsigned rows        = 4,
    parameter int unsigned columns     = 3,
    parameter int unsigned max_rows    = 4,
    parameter int unsigned max_columns = 3,
    parameter int unsigned datawidth   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_overall,
    input  logic                                 load_start,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [max_columns*datawidth-1:0]     s_weights,
    input  logic [2*datawidth-1:0]               s_bias,
    output logic [$clog2(max_rows)-1:0]          row_sel,
    output logic [max_columns*datawidth-1:0]     weight_update,
    output logic [max_rows*2*datawidth-1:0]      bias_updates,
    output logic                                 train_en,
    output logic                                 busy,
`ifdef LAYER_LOADER_CHECKSUM_EN
    output logic                                 loaded,
    output logic [CHECKSUM_W-1:0]                checksum
`else
    output logic                                 loaded
`endif
);

    localparam int unsigned RSW = $clog2(max_rows);
    localparam int unsigned CW  = RSW + 1;
    localparam int unsigned BW  = 2 * datawidth;
    localparam int unsigned WW  = max_columns * datawidth;

    loader_state_t           state_q, state_d;
    logic [CW-1:0]           row_cnt_q, row_cnt_d;
    logic [RSW-1:0]          row_sel_q, row_sel_d;
    logic [WW-1:0]           weight_q, weight_d;
    logic [max_rows*BW-1:0]  bias_q, bias_d;
    logic                    train_en_q, train_en_d;
    logic                    loaded_q, loaded_d;
    logic                    accept;
`ifdef LAYER_LOADER_CHECKSUM_EN
    logic [CHECKSUM_W-1:0]   checksum_q, checksum_d;
`endif

    // Ready drops as soon as the last row is taken, so LOAD spends one
    // extra cycle presenting the final write before entering DONE.
    assign s_ready = (state_q == LOAD) && (row_cnt_q < CW'(rows));
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        row_sel_d  = row_sel_q;
        weight_d   = weight_q;
        bias_d     = bias_q;
        train_en_d = 1'b0;
        loaded_d   = loaded_q;
`ifdef LAYER_LOADER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (load_start) begin
                    state_d   = LOAD;
                    row_cnt_d = '0;
                    loaded_d  = 1'b0;
                    bias_d    = '0;
`ifdef LAYER_LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            LOAD: begin
                if (accept) begin
                    row_sel_d  = row_cnt_q[RSW-1:0];
                    weight_d   = s_weights;
                    train_en_d = 1'b1;
                    row_cnt_d  = row_cnt_q + CW'(1);
                    for (int unsigned r = 0; r < max_rows; r++) begin
                        if (row_cnt_q == CW'(r)) begin
                            bias_d[bias_lsb(r, max_rows, datawidth) +: BW] = s_bias;
                        end
                    end
`ifdef LAYER_LOADER_CHECKSUM_EN
                    checksum_d = checksum_q + CHECKSUM_W'(s_weights)
                               + CHECKSUM_W'($signed(s_bias));
`endif
                end else if (row_cnt_q == CW'(rows)) begin
                    state_d  = DONE;
                    loaded_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_overall) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            row_sel_q  <= '0;
            weight_q   <= '0;
            bias_q     <= '0;
            train_en_q <= 1'b0;
            loaded_q   <= 1'b0;
`ifdef LAYER_LOADER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            row_sel_q  <= row_sel_d;
            weight_q   <= weight_d;
            bias_q     <= bias_d;
            train_en_q <= train_en_d;
            loaded_q   <= loaded_d;
`ifdef LAYER_LOADER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    assign row_sel       = row_sel_q;
    assign weight_update = weight_q;
    assign bias_updates  = bias_q;
    assign train_en      = train_en_q;
    assign busy          = (state_q == LOAD);
    assign loaded        = loaded_q;
`ifdef LAYER_LOADER_CHECKSUM_EN
    assign checksum      = checksum_q;
`endif

endmodule

// File: tb/tb_layer_param_loader.sv
// Directed plus randomized bench for layer_param_loader against a row-level reference model.
module tb_layer_param_loader;

    logic        clk = 1'b0;
    logic        rst_overall = 1'b1;
    logic        load_start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_weights = '0;
    logic [7:0]  s_bias = '0;
    logic [1:0]  row_sel;
    logic [11:0] weight_update;
    logic [31:0] bias_updates;
    logic        train_en;
    logic        busy;
    logic        loaded;
`ifdef LAYER_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    layer_param_loader #(
        .rows(4), .columns(3), .max_rows(4), .max_columns(3), .datawidth(4)
    ) dut (
        .clk(clk),
        .rst_overall(rst_overall),
        .load_start(load_start),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_weights(s_weights),
        .s_bias(s_bias),
        .row_sel(row_sel),
        .weight_update(weight_update),
        .bias_updates(bias_updates),
        .train_en(train_en),
        .busy(busy),
`ifdef LAYER_LOADER_CHECKSUM_EN
        .loaded(loaded),
        .checksum(checksum)
`else
        .loaded(loaded)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a loading flag, a count of rows taken, and per-row bias values.
    bit          m_loading;
    bit          m_loaded;
    bit          m_te;
    int          m_cnt;
    logic [1:0]  m_row;
    logic [11:0] m_w;
    logic [7:0]  m_bias [4];
    logic [15:0] m_cs;

    int          te_pulses;
    int          te_rows [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_loading = 0; m_loaded = 0; m_te = 0; m_cnt = 0;
        m_row = '0; m_w = '0; m_cs = '0;
        for (int i = 0; i < 4; i++) m_bias[i] = '0;
    endtask

    task automatic cycle(input bit rst, input bit ls, input bit v,
                         input logic [11:0] w, input logic [7:0] b);
        bit acc;
        bit finish_load;
        rst_overall = rst; load_start = ls; s_valid = v; s_weights = w; s_bias = b;
        acc = m_loading && (m_cnt < 4) && v;
        finish_load = m_loading && m_te && (m_cnt == 4);
        @(posedge clk); #1;
        if (rst) begin
            model_reset();
        end else if (!m_loading) begin
            m_te = 0;
            if (ls) begin
                m_loading = 1; m_cnt = 0; m_loaded = 0; m_cs = '0;
                for (int i = 0; i < 4; i++) m_bias[i] = '0;
            end
        end else begin
            m_te = acc;
            if (acc) begin
                m_row = 2'(m_cnt);
                m_w = w;
                m_bias[m_cnt] = b;
                m_cnt++;
                m_cs = m_cs + 16'(w) + 16'(int'($signed(b)));
            end
            if (finish_load) begin
                m_loading = 0;
                m_loaded = 1;
            end
        end
        chk("train_en", 32'(train_en), 32'(m_te));
        chk("s_ready", 32'(s_ready), 32'(m_loading && m_cnt < 4));
        chk("busy", 32'(busy), 32'(m_loading));
        chk("loaded", 32'(loaded), 32'(m_loaded));
        chk("bias_updates", bias_updates, {m_bias[0], m_bias[1], m_bias[2], m_bias[3]});
        chk("row_sel", 32'(row_sel), 32'(m_row));
        chk("weight_update", 32'(weight_update), 32'(m_w));
`ifdef LAYER_LOADER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(m_cs));
`endif
        if (train_en === 1'b1) begin
            te_pulses++;
            te_rows.push_back(int'(row_sel));
        end
    endtask

    logic [7:0] biases [4];

    initial begin
        biases[0] = 8'd100; biases[1] = 8'hEC; biases[2] = 8'd35; biases[3] = 8'hF4;
        model_reset();

        // Reset held two cycles
        cycle(1, 0, 0, '0, '0);
        cycle(1, 0, 0, '0, '0);
        chk("reset_bias", bias_updates, 32'h0);

        // Back-to-back load
        cycle(0, 1, 1, 12'h2F5, 8'h11);
        te_pulses = 0; te_rows.delete();
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 12'h2F5, biases[i]);
        cycle(0, 0, 0, '0, '0);
        chk("b2b_pulses", 32'(te_pulses), 32'd4);
        for (int i = 0; i < 4; i++) chk("b2b_row_seq", 32'(te_rows[i]), 32'(i));
        chk("b2b_bias_final", bias_updates, 32'h64EC23F4);
        chk("b2b_loaded", 32'(loaded), 32'd1);
`ifdef LAYER_LOADER_CHECKSUM_EN
        chk("checksum_final", 32'(checksum), 32'h0C3B);
`endif
        // s_valid while DONE is ignored
        cycle(0, 0, 1, 12'hFFF, 8'hFF);
        cycle(0, 0, 1, 12'hFFF, 8'hFF);

        // Gapped load: valid every other cycle, load_start pulsed mid-load
        cycle(0, 1, 0, '0, '0);
        te_pulses = 0; te_rows.delete();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 12'h2F5, biases[i]);
            cycle(0, (i == 1), 0, '0, '0);
        end
        cycle(0, 0, 0, '0, '0);
        chk("gap_pulses", 32'(te_pulses), 32'd4);
        for (int i = 0; i < 4; i++) chk("gap_row_seq", 32'(te_rows[i]), 32'(i));
        chk("gap_bias_final", bias_updates, 32'h64EC23F4);

        // Reset after two accepted beats, then a fresh load
        cycle(0, 1, 0, '0, '0);
        cycle(0, 0, 1, 12'h123, 8'h05);
        cycle(0, 0, 1, 12'h456, 8'h06);
        cycle(1, 0, 0, '0, '0);
        chk("midreset_bias", bias_updates, 32'h0);
        cycle(0, 1, 1, 12'h777, 8'h07);
        te_pulses = 0; te_rows.delete();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 12'(i + 1), 8'(i + 9));
            if (i < 3) chk("restart_not_loaded", 32'(loaded), 32'd0);
        end
        cycle(0, 0, 0, '0, '0);
        chk("restart_first_row", 32'(te_rows[0]), 32'd0);
        chk("restart_loaded", 32'(loaded), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 1), 12'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
